mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width.
REQ-002 SHALL have parameter DATA_W, default 8, data width.
REQ-003 SHALL have parameter DEPTH, default 4096, number of backed bytes; valid addresses are 0..DEPTH-1.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, wait states inserted before the response (0..15).
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  reset.
REQ-006 SHALL have port read_enable  in  1  read request strobe, held high until ready.
REQ-007 SHALL have port write_enable  in  1  write request strobe, held high until ready.
REQ-008 SHALL have port addr  in  ADDR_W  request address.
REQ-009 SHALL have port data_in  in  DATA_W  write data.
REQ-010 SHALL have port data_out  out  DATA_W  read data, held until the next completed read.
REQ-011 SHALL have port ready  out  1  one-cycle transaction-complete pulse.
REQ-012 SHALL have port err  out  1  one-cycle error pulse, coincident with ready.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 In IDLE, a sampled strobe SHALL latch addr, data_in and op, then go to WAIT (or straight to RESP if WAIT_CYCLES=0).
REQ-015 WAIT SHALL count exactly WAIT_CYCLES cycles, then go to RESP.
REQ-016 Latency SHALL be fixed: strobe first high in cycle N gives ready=1 in cycle N+WAIT_CYCLES+1.
REQ-017 RESP SHALL assert ready for exactly one cycle and commit the access: write updates RAM at that edge; read drives data_out=RAM[addr] in the same cycle as ready.
REQ-018 RESP SHALL always return to IDLE; the requester drops its strobe in the cycle after ready, so at least one IDLE cycle separates transactions.
REQ-019 If both strobes are high when sampled, the transaction SHALL complete with ready=1 and err=1, with no RAM change and data_out unchanged.
REQ-020 If addr >= DEPTH, the transaction SHALL complete with ready=1 and err=1; a read returns 0x00 and a write is dropped.
REQ-021 If the strobe is deasserted during WAIT, the FSM SHALL abort to IDLE with no access, no ready and no err.
REQ-022 Addresses and data SHALL be taken from the values latched in IDLE; input changes during WAIT SHALL be ignored.

Reset
REQ-023 On rst, the FSM SHALL enter IDLE and the wait counter SHALL clear to 0.
REQ-024 On rst, outputs SHALL clear: ready=0, err=0, data_out=0x00.
REQ-025 A reset mid-transaction SHALL abort it without committing the write.
REQ-026 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro MEM_IO_PORT_EN, when defined, SHALL add ports io_port (out, DATA_W) and io_strobe (out, 1), both reset to 0.
REQ-028 With MEM_IO_PORT_EN defined, a write to address 0xFFFF SHALL load io_port and pulse io_strobe coincident with ready, with err=0.
REQ-029 With MEM_IO_PORT_EN defined, a read of address 0xFFFF SHALL return io_port.
REQ-030 Without MEM_IO_PORT_EN, the io_port and io_strobe ports SHALL be absent and 0xFFFF SHALL follow REQ-020 whenever DEPTH <= 0xFFFF.

Structure
REQ-031 Package mem_pkg SHALL hold the FSM state enum, the IO_ADDR constant (16'hFFFF) and the default ADDR_W and DATA_W values.
REQ-032 Storage SHALL be a sub-module mem_ram_sp: single-port synchronous RAM, DEPTH x DATA_W, write-enable only, no reset.

Verification
REQ-033 With WAIT_CYCLES=2: write 0x5A to 0x0010 with the strobe in cycle 0 -> ready=1 in cycle 3, err=0; a following read of 0x0010 -> data_out=0x5A coincident with ready.
REQ-034 With WAIT_CYCLES=0: read of 0x0010 -> ready in cycle 1; then read 0x0011 (never written, preloaded 0x00) -> data_out=0x00.
REQ-035 With DEPTH=4096: write 0x77 to 0x1000 -> ready=1, err=1; then read 0x0FFF -> returns the previously written value, unchanged.
REQ-036 Both strobes high on 0x0020 -> ready=1, err=1, RAM[0x0020] unchanged, data_out unchanged.
REQ-037 With WAIT_CYCLES=3: strobe dropped in WAIT cycle 2 -> no ready; and rst asserted mid-WAIT during a write of 0xAA to 0x0030 -> a later read of 0x0030 returns the old value.
REQ-038 With MEM_IO_PORT_EN defined: write 0xC3 to 0xFFFF -> io_port=0xC3, io_strobe=1 for one cycle, err=0; a read of 0xFFFF -> data_out=0xC3.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder memory slave.
package mem_pkg;

    localparam int          ADDR_W_DEF = 16;
    localparam int          DATA_W_DEF = 8;
    localparam logic [15:0] IO_ADDR    = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_ram_sp.sv
// Single-port synchronous RAM, DEPTH x DATA_W, read-before-write, no reset.
module mem_ram_sp #(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 8,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-mapped responder with fixed wait-state latency over a single-port RAM.
// Optional MEM_IO_PORT_EN adds an output register mapped at IO_ADDR.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_enable,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              ready,
`ifdef MEM_IO_PORT_EN
    output logic [DATA_W-1:0] io_port,
    output logic              io_strobe,
`endif
    output logic              err
);

    localparam int         RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic              strobe, held, out_of_range;
`ifdef MEM_IO_PORT_EN
    logic [DATA_W-1:0] io_port_q, io_port_d;
    logic              io_hit;
    assign io_hit  = (addr_q == ADDR_W'(IO_ADDR));
    assign io_port = io_port_q;
`endif

    assign strobe       = read_enable | write_enable;
    assign held         = (rd_q & read_enable) | (wr_q & write_enable);
    assign out_of_range = (64'(addr_q) >= 64'(DEPTH));
    // The RAM read is launched one edge before RESP; with zero wait states that edge is the IDLE sample.
    assign ram_addr     = (state_q == IDLE) ? addr[RAM_AW-1:0] : addr_q[RAM_AW-1:0];

    mem_ram_sp #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(RAM_AW)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        dout_d   = dout_q;
        data_out = dout_q;
        ready    = 1'b0;
        err      = 1'b0;
        ram_we   = 1'b0;
`ifdef MEM_IO_PORT_EN
        io_port_d = io_port_q;
        io_strobe = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (strobe) begin
                    addr_d  = addr;
                    wdata_d = data_in;
                    rd_d    = read_enable;
                    wr_d    = write_enable;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!held) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_WAIT) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                ready   = 1'b1;
                state_d = IDLE;
                cnt_d   = 4'd0;
                if (rd_q && wr_q) begin
                    err = 1'b1;
`ifdef MEM_IO_PORT_EN
                end else if (io_hit) begin
                    if (wr_q) begin
                        io_port_d = wdata_q;
                        io_strobe = 1'b1;
                    end else begin
                        data_out = io_port_q;
                        dout_d   = io_port_q;
                    end
`endif
                end else if (out_of_range) begin
                    err = 1'b1;
                    if (rd_q) begin
                        data_out = '0;
                        dout_d   = '0;
                    end
                end else if (wr_q) begin
                    ram_we = 1'b1;
                end else begin
                    data_out = ram_rdata;
                    dout_d   = ram_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            dout_q  <= '0;
`ifdef MEM_IO_PORT_EN
            io_port_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
`ifdef MEM_IO_PORT_EN
            io_port_q <= io_port_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rd_q    <= rd_d;
        wr_q    <= wr_d;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances (2, 0 and 3 wait states), optional MEM_IO_PORT_EN.
module tb_mem_responder;

    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst, rd, wr, rdy, er;
    logic [15:0] ad [3];
    logic [7:0]  di [3];
    logic [7:0]  dq [3];
`ifdef MEM_IO_PORT_EN
    logic [7:0]  iop [3];
    logic [2:0]  ios;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] mm [3][DEPTH];
    logic [7:0] mdout [3];
    logic       io_seen;

    mem_responder #(.ADDR_W(16), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .rst(rst[0]), .read_enable(rd[0]), .write_enable(wr[0]), .addr(ad[0]),
        .data_in(di[0]), .data_out(dq[0]), .ready(rdy[0]),
`ifdef MEM_IO_PORT_EN
        .io_port(iop[0]), .io_strobe(ios[0]),
`endif
        .err(er[0]));

    mem_responder #(.ADDR_W(16), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst[1]), .read_enable(rd[1]), .write_enable(wr[1]), .addr(ad[1]),
        .data_in(di[1]), .data_out(dq[1]), .ready(rdy[1]),
`ifdef MEM_IO_PORT_EN
        .io_port(iop[1]), .io_strobe(ios[1]),
`endif
        .err(er[1]));

    mem_responder #(.ADDR_W(16), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u2 (
        .clk(clk), .rst(rst[2]), .read_enable(rd[2]), .write_enable(wr[2]), .addr(ad[2]),
        .data_in(di[2]), .data_out(dq[2]), .ready(rdy[2]),
`ifdef MEM_IO_PORT_EN
        .io_port(iop[2]), .io_strobe(ios[2]),
`endif
        .err(er[2]));

    function automatic int wcyc(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
    endfunction

    // One request on instance k; lat is the cycle (strobe cycle = 0) in which ready was seen, -1 on timeout.
    task automatic run_txn(input int k, input logic r, input logic w, input logic [15:0] a,
                           input logic [7:0] d, output int lat, output logic e,
                           output logic [7:0] q, output logic one_pulse);
        lat = -1; e = 1'b0; q = 8'h00; io_seen = 1'b0;
        @(negedge clk);
        rd[k] = r; wr[k] = w; ad[k] = a; di[k] = d;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rdy[k]) begin
                lat = c; e = er[k]; q = dq[k];
`ifdef MEM_IO_PORT_EN
                io_seen = ios[k];
`endif
                break;
            end
        end
        rd[k] = 1'b0; wr[k] = 1'b0;
        ad[k] = 16'($urandom); di[k] = 8'($urandom);
        @(negedge clk);
        one_pulse = !rdy[k] && !er[k];
`ifdef MEM_IO_PORT_EN
        one_pulse = one_pulse && !ios[k];
`endif
    endtask

    // Behavioural expectation for a completed transaction; returns expected err and data_out at ready.
    task automatic model_txn(input int k, input logic r, input logic w, input logic [15:0] a,
                             input logic [7:0] d, output logic e, output logic [7:0] q);
        if (r && w) begin
            e = 1'b1;
        end else if (int'(a) >= DEPTH) begin
            e = 1'b1;
            if (r) mdout[k] = 8'h00;
        end else begin
            e = 1'b0;
            if (w) mm[k][a] = d;
            else   mdout[k] = mm[k][a];
        end
        q = mdout[k];
    endtask

    task automatic preload();
        int lat; logic e, p; logic [7:0] q;
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 64; a++) run_txn(k, 1'b0, 1'b1, 16'(a), 8'h00, lat, e, q, p);
            run_txn(k, 1'b0, 1'b1, 16'h0FFF, 8'h00, lat, e, q, p);
        end
    endtask

    task automatic test_reset();
        rst = 3'b111; rd = '0; wr = '0;
        for (int k = 0; k < 3; k++) begin ad[k] = '0; di[k] = '0; end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++; if (rdy[k] !== 1'b0) begin bad++; $display("FAIL reset_ready k=%0d got=%b exp=0", k, rdy[k]); end
            total++; if (er[k] !== 1'b0) begin bad++; $display("FAIL reset_err k=%0d got=%b exp=0", k, er[k]); end
            total++; if (dq[k] !== 8'h00) begin bad++; $display("FAIL reset_dout k=%0d got=%h exp=00", k, dq[k]); end
`ifdef MEM_IO_PORT_EN
            total++; if (iop[k] !== 8'h00 || ios[k] !== 1'b0) begin bad++; $display("FAIL reset_io k=%0d got=%h/%b exp=00/0", k, iop[k], ios[k]); end
`endif
        end
        rst = 3'b000;
        repeat (2) @(negedge clk);
        total++; if (rdy !== 3'b000) begin bad++; $display("FAIL idle_ready got=%b exp=000", rdy); end
    endtask

    task automatic test_wait2();
        int lat; logic e, p; logic [7:0] q;
        run_txn(0, 1'b0, 1'b1, 16'h0010, 8'h5A, lat, e, q, p); mm[0][16'h10] = 8'h5A;
        total++; if (lat !== 3) begin bad++; $display("FAIL w2_wr_lat got=%0d exp=3", lat); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL w2_wr_err got=%b exp=0", e); end
        total++; if (p !== 1'b1) begin bad++; $display("FAIL w2_wr_pulse got=%b exp=1", p); end
        run_txn(0, 1'b1, 1'b0, 16'h0010, 8'h00, lat, e, q, p); mdout[0] = 8'h5A;
        total++; if (lat !== 3) begin bad++; $display("FAIL w2_rd_lat got=%0d exp=3", lat); end
        total++; if (q !== 8'h5A) begin bad++; $display("FAIL w2_rd_data got=%h exp=5a", q); end
        total++; if (dq[0] !== 8'h5A) begin bad++; $display("FAIL w2_rd_hold got=%h exp=5a", dq[0]); end
    endtask

    task automatic test_wait0();
        int lat; logic e, p; logic [7:0] q;
        run_txn(1, 1'b1, 1'b0, 16'h0010, 8'h00, lat, e, q, p);
        total++; if (lat !== 1) begin bad++; $display("FAIL w0_rd_lat got=%0d exp=1", lat); end
        run_txn(1, 1'b0, 1'b1, 16'h0012, 8'h3C, lat, e, q, p); mm[1][16'h12] = 8'h3C;
        run_txn(1, 1'b1, 1'b0, 16'h0012, 8'h00, lat, e, q, p);
        total++; if (q !== 8'h3C) begin bad++; $display("FAIL w0_rd12 got=%h exp=3c", q); end
        run_txn(1, 1'b1, 1'b0, 16'h0011, 8'h00, lat, e, q, p); mdout[1] = 8'h00;
        total++; if (lat !== 1 || q !== 8'h00) begin bad++; $display("FAIL w0_rd11 got=%0d/%h exp=1/00", lat, q); end
    endtask

    task automatic test_range();
        int lat; logic e, p; logic [7:0] q;
        run_txn(0, 1'b0, 1'b1, 16'h0FFF, 8'h42, lat, e, q, p); mm[0][16'h0FFF] = 8'h42;
        total++; if (e !== 1'b0) begin bad++; $display("FAIL last_wr_err got=%b exp=0", e); end
        run_txn(0, 1'b0, 1'b1, 16'h1000, 8'h77, lat, e, q, p);
        total++; if (lat !== 3 || e !== 1'b1) begin bad++; $display("FAIL oor_wr got=%0d/%b exp=3/1", lat, e); end
        run_txn(0, 1'b1, 1'b0, 16'h0FFF, 8'h00, lat, e, q, p); mdout[0] = 8'h42;
        total++; if (q !== 8'h42 || e !== 1'b0) begin bad++; $display("FAIL last_rd got=%h/%b exp=42/0", q, e); end
        run_txn(0, 1'b1, 1'b0, 16'h1000, 8'h00, lat, e, q, p); mdout[0] = 8'h00;
        total++; if (q !== 8'h00 || e !== 1'b1) begin bad++; $display("FAIL oor_rd got=%h/%b exp=00/1", q, e); end
    endtask

    task automatic test_both();
        int lat; logic e, p; logic [7:0] q;
        run_txn(0, 1'b0, 1'b1, 16'h0020, 8'h99, lat, e, q, p); mm[0][16'h20] = 8'h99;
        run_txn(0, 1'b1, 1'b0, 16'h0010, 8'h00, lat, e, q, p); mdout[0] = 8'h5A;
        run_txn(0, 1'b1, 1'b1, 16'h0020, 8'h11, lat, e, q, p);
        total++; if (lat !== 3 || e !== 1'b1) begin bad++; $display("FAIL both_resp got=%0d/%b exp=3/1", lat, e); end
        total++; if (q !== 8'h5A) begin bad++; $display("FAIL both_dout got=%h exp=5a", q); end
        run_txn(0, 1'b1, 1'b0, 16'h0020, 8'h00, lat, e, q, p); mdout[0] = 8'h99;
        total++; if (q !== 8'h99) begin bad++; $display("FAIL both_ram got=%h exp=99", q); end
    endtask

    task automatic test_abort();
        int lat, seen; logic e, p; logic [7:0] q;
        @(negedge clk); rd[2] = 1'b1; ad[2] = 16'h0010;
        @(negedge clk);
        @(negedge clk); rd[2] = 1'b0;
        seen = 0;
        repeat (8) begin @(negedge clk); if (rdy[2] || er[2]) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_ready got=%0d exp=0", seen); end
        run_txn(2, 1'b0, 1'b1, 16'h0030, 8'h11, lat, e, q, p); mm[2][16'h30] = 8'h11;
        total++; if (lat !== 4) begin bad++; $display("FAIL w3_lat got=%0d exp=4", lat); end
        run_txn(2, 1'b1, 1'b0, 16'h0030, 8'h00, lat, e, q, p); mdout[2] = 8'h11;
        @(negedge clk); wr[2] = 1'b1; ad[2] = 16'h0030; di[2] = 8'hAA;
        @(negedge clk);
        @(negedge clk); rst[2] = 1'b1; wr[2] = 1'b0;
        @(negedge clk); rst[2] = 1'b0; mdout[2] = 8'h00;
        total++; if (dq[2] !== 8'h00 || rdy[2] !== 1'b0) begin bad++; $display("FAIL midrst_out got=%h/%b exp=00/0", dq[2], rdy[2]); end
        run_txn(2, 1'b1, 1'b0, 16'h0030, 8'h00, lat, e, q, p); mdout[2] = 8'h11;
        total++; if (q !== 8'h11 || lat !== 4) begin bad++; $display("FAIL midrst_ram got=%h/%0d exp=11/4", q, lat); end
    endtask

    task automatic test_io();
        int lat; logic e, p; logic [7:0] q;
        run_txn(0, 1'b0, 1'b1, 16'hFFFF, 8'hC3, lat, e, q, p);
`ifdef MEM_IO_PORT_EN
        total++; if (e !== 1'b0 || io_seen !== 1'b1) begin bad++; $display("FAIL io_wr got=%b/%b exp=0/1", e, io_seen); end
        total++; if (iop[0] !== 8'hC3 || p !== 1'b1) begin bad++; $display("FAIL io_port got=%h/%b exp=c3/1", iop[0], p); end
        run_txn(0, 1'b1, 1'b0, 16'hFFFF, 8'h00, lat, e, q, p); mdout[0] = 8'hC3;
        total++; if (q !== 8'hC3 || e !== 1'b0) begin bad++; $display("FAIL io_rd got=%h/%b exp=c3/0", q, e); end
`else
        total++; if (e !== 1'b1 || lat !== 3) begin bad++; $display("FAIL ffff_wr got=%b/%0d exp=1/3", e, lat); end
        run_txn(0, 1'b1, 1'b0, 16'hFFFF, 8'h00, lat, e, q, p); mdout[0] = 8'h00;
        total++; if (q !== 8'h00 || e !== 1'b1) begin bad++; $display("FAIL ffff_rd got=%h/%b exp=00/1", q, e); end
`endif
    endtask

    task automatic test_random(input int k, input int n);
        int lat, sel; logic r, w, e, p, ee; logic [7:0] q, eq, d; logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            sel = int'($urandom_range(0, 9));
            r = $urandom_range(0, 1) == 1; w = !r;
            d = 8'($urandom);
            if (sel < 7)       a = 16'($urandom_range(0, 63));
            else if (sel == 7) a = ($urandom_range(0, 1) == 1) ? 16'h0FFF : 16'h1000;
            else if (sel == 8) a = 16'($urandom_range(DEPTH, 16'hFFFE));
            else begin a = 16'($urandom_range(0, 63)); r = 1'b1; w = 1'b1; end
            model_txn(k, r, w, a, d, ee, eq);
            run_txn(k, r, w, a, d, lat, e, q, p);
            total++; if (lat !== wcyc(k) + 1) begin bad++; $display("FAIL rnd_lat k=%0d i=%0d got=%0d exp=%0d", k, i, lat, wcyc(k) + 1); end
            total++; if (e !== ee) begin bad++; $display("FAIL rnd_err k=%0d i=%0d a=%h got=%b exp=%b", k, i, a, e, ee); end
            total++; if (q !== eq) begin bad++; $display("FAIL rnd_data k=%0d i=%0d a=%h got=%h exp=%h", k, i, a, q, eq); end
            total++; if (p !== 1'b1) begin bad++; $display("FAIL rnd_pulse k=%0d i=%0d got=%b exp=1", k, i, p); end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            mdout[k] = 8'h00;
            for (int a = 0; a < DEPTH; a++) mm[k][a] = 8'h00;
        end
        test_reset();
        preload();
        test_wait2();
        test_wait0();
        test_range();
        test_both();
        test_abort();
        test_io();
        test_random(0, 60);
        test_random(1, 60);
        test_random(2, 30);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
